// File: rtl/game_regmap.sv
// rtl/game_regmap.sv - shared game register map and shadow parameters
package game_regmap;

  localparam int NUM_SLOTS   = 8;
  localparam int BASE_REG    = 20;
  localparam int COMMIT_REG  = 28;
  localparam int STALE_LIMIT = 4;
  localparam int SEQ_W       = 8;

  localparam int SLOT_BALL_X = 0;
  localparam int SLOT_BALL_Y = 1;
  localparam int SLOT_PAD_L  = 2;
  localparam int SLOT_PAD_R  = 3;
  localparam int SLOT_SCORE  = 4;

  // pending flag doubles as the FSM state encoding
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } pend_state_e;

  // true when the writeback bus carries the frame-complete marker
  function automatic logic is_commit_write(input logic we, input logic [4:0] wreg, input int commit_reg);
    return we && (wreg == 5'(commit_reg));
  endfunction

endpackage

// File: rtl/game_state_shadow_if.sv
// rtl/game_state_shadow_if.sv - processor register-writeback snoop bus
interface game_state_shadow_if;

  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  // processor side drives the writeback
  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output data_writeReg
  );

  // shadow side only observes
  modport slave (
    input ctrl_writeEnable,
    input ctrl_writeReg,
    input data_writeReg
  );

endinterface

// File: rtl/shadow_bank.sv
// rtl/shadow_bank.sv - register window shadow with write decode and flat read-out
module shadow_bank #(
  parameter int NUM_SLOTS = 8,
  parameter int BASE_REG  = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [4:0]             wr_reg,
  input  logic [31:0]            wr_data,
  output logic [32*NUM_SLOTS-1:0] rd_flat
);

  logic [31:0] shadow_q [NUM_SLOTS];
  logic [31:0] shadow_d [NUM_SLOTS];

  // decode the writeback index against each slot; out-of-window writes fall through untouched
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (wr_en && (wr_reg == 5'(BASE_REG + i))) begin
        shadow_d[i] = wr_data;
      end
    end
  end

  // shadow storage
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
    assign rd_flat[32*g +: 32] = shadow_q[g];
  end

endmodule

// File: rtl/game_state_shadow.sv
// rtl/game_state_shadow.sv - frame-coherent snapshot of shadowed game registers
module game_state_shadow
  import game_regmap::*;
#(
  parameter int NUM_SLOTS   = game_regmap::NUM_SLOTS,
  parameter int BASE_REG    = game_regmap::BASE_REG,
  parameter int COMMIT_REG  = game_regmap::COMMIT_REG,
  parameter int STALE_LIMIT = game_regmap::STALE_LIMIT
) (
  input  logic                     clock,
  input  logic                     reset,
  game_state_shadow_if.slave       wb,
  input  logic                     frame_req,
  output logic [32*NUM_SLOTS-1:0]  snap_data,
  output logic                     snap_valid,
  output logic [SEQ_W-1:0]         snap_seq,
  output logic                     frame_ack,
  output logic                     frame_updated,
  output logic                     stale
);

  logic [32*NUM_SLOTS-1:0] shadow_flat;

  shadow_bank #(
    .NUM_SLOTS (NUM_SLOTS),
    .BASE_REG  (BASE_REG)
  ) u_shadow_bank (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wb.ctrl_writeEnable),
    .wr_reg  (wb.ctrl_writeReg),
    .wr_data (wb.data_writeReg),
    .rd_flat (shadow_flat)
  );

  pend_state_e             state_q, state_d;
  logic                    frame_req_q, frame_req_d;
  logic [32*NUM_SLOTS-1:0] snap_data_q, snap_data_d;
  logic                    snap_valid_q, snap_valid_d;
  logic [SEQ_W-1:0]        snap_seq_q, snap_seq_d;
  logic [7:0]              stale_cnt_q, stale_cnt_d;
  logic                    frame_ack_q, frame_ack_d;
  logic                    frame_updated_q, frame_updated_d;

  logic req_edge;
  logic commit;
  logic publish;

  // edge detect, pending FSM and publish datapath; publish sees pre-edge shadow and pending
  always_comb begin
    frame_req_d     = frame_req;
    state_d         = state_q;
    snap_data_d     = snap_data_q;
    snap_valid_d    = snap_valid_q;
    snap_seq_d      = snap_seq_q;
    stale_cnt_d     = stale_cnt_q;
    frame_ack_d     = 1'b0;
    frame_updated_d = 1'b0;

    req_edge = frame_req && !frame_req_q;
    commit   = is_commit_write(wb.ctrl_writeEnable, wb.ctrl_writeReg, COMMIT_REG);
    publish  = req_edge && (state_q == ST_PENDING);

    case (state_q)
      ST_IDLE: begin
        if (commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        // a commit on the publishing edge is kept for the next frame
        if (req_edge && !commit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (publish) begin
      snap_data_d  = shadow_flat;
      snap_valid_d = 1'b1;
      snap_seq_d   = snap_seq_q + 1'b1;
      stale_cnt_d  = '0;
    end else if (req_edge && (stale_cnt_q != 8'(STALE_LIMIT))) begin
      stale_cnt_d = stale_cnt_q + 1'b1;
    end

    if (req_edge) begin
      frame_ack_d     = 1'b1;
      frame_updated_d = publish;
    end
  end

  // state registers; reset overrides any same-edge request or commit
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      frame_req_q     <= 1'b0;
      snap_data_q     <= '0;
      snap_valid_q    <= 1'b0;
      snap_seq_q      <= '0;
      stale_cnt_q     <= '0;
      frame_ack_q     <= 1'b0;
      frame_updated_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_req_q     <= frame_req_d;
      snap_data_q     <= snap_data_d;
      snap_valid_q    <= snap_valid_d;
      snap_seq_q      <= snap_seq_d;
      stale_cnt_q     <= stale_cnt_d;
      frame_ack_q     <= frame_ack_d;
      frame_updated_q <= frame_updated_d;
    end
  end

  assign snap_data     = snap_data_q;
  assign snap_valid    = snap_valid_q;
  assign snap_seq      = snap_seq_q;
  assign frame_ack     = frame_ack_q;
  assign frame_updated = frame_updated_q;
  assign stale         = (stale_cnt_q == 8'(STALE_LIMIT));

endmodule

// File: tb/tb_game_state_shadow.sv
// tb/tb_game_state_shadow.sv - scoreboard bench for game_state_shadow
module tb_game_state_shadow;
  import game_regmap::*;

  localparam int W = 32 * NUM_SLOTS;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           frame_req = 1'b0;
  logic [W-1:0]   snap_data;
  logic           snap_valid;
  logic [7:0]     snap_seq;
  logic           frame_ack;
  logic           frame_updated;
  logic           stale;

  game_state_shadow_if wb ();

  game_state_shadow u_dut (
    .clock         (clock),
    .reset         (reset),
    .wb            (wb.slave),
    .frame_req     (frame_req),
    .snap_data     (snap_data),
    .snap_valid    (snap_valid),
    .snap_seq      (snap_seq),
    .frame_ack     (frame_ack),
    .frame_updated (frame_updated),
    .stale         (stale)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic         upd;
    logic [7:0]   seq;
    logic         valid;
    logic         stl;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int vectors = 0;
  int miscompares = 0;
  int ack_count = 0;

  logic [W-1:0] m_shadow;
  logic [W-1:0] m_snap;
  logic [7:0]   m_seq;
  logic         m_valid;
  logic         m_pend;
  int           m_stale_cnt;
  logic         m_prev_req;

  // reference behaviour for one clock edge
  task automatic model_edge(input logic rst, input logic req, input logic we,
                            input logic [4:0] r, input logic [31:0] d);
    logic edge_k;
    logic pub;
    if (rst) begin
      m_shadow = '0; m_snap = '0; m_seq = '0; m_valid = 1'b0;
      m_pend = 1'b0; m_stale_cnt = 0; m_prev_req = 1'b0;
      return;
    end
    edge_k = req && !m_prev_req;
    m_prev_req = req;
    pub = edge_k && m_pend;
    if (pub) begin
      m_snap = m_shadow;
      m_seq = m_seq + 8'd1;
      m_valid = 1'b1;
      m_stale_cnt = 0;
    end else if (edge_k && m_stale_cnt < STALE_LIMIT) begin
      m_stale_cnt++;
    end
    if (edge_k) exp_q.push_back('{pub, m_seq, m_valid, (m_stale_cnt == STALE_LIMIT), m_snap});
    if (we && r == 5'(COMMIT_REG)) m_pend = 1'b1;
    else if (pub) m_pend = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (we && r == 5'(BASE_REG + i)) m_shadow[32*i +: 32] = d;
  endtask

  // apply one cycle of inputs; they are consumed by the next rising edge
  task automatic step(input logic rst, input logic req, input logic we,
                      input logic [4:0] r, input logic [31:0] d);
    reset = rst;
    frame_req = req;
    wb.ctrl_writeEnable = we;
    wb.ctrl_writeReg = r;
    wb.data_writeReg = d;
    @(posedge clock);
    #1;
    model_edge(rst, req, we, r, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    step(1'b0, 1'b0, 1'b1, r, d);
  endtask

  task automatic request();
    step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(1);
  endtask

  // compare each ack against the oldest outstanding expectation
  always @(negedge clock) begin
    if (frame_ack) begin
      ack_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ack: got frame_ack=1 with no request outstanding, required none");
      end else begin
        e = exp_q.pop_front();
        if (frame_updated !== e.upd) begin
          miscompares++;
          $display("FAIL ack_updated: got %0b required %0b", frame_updated, e.upd);
        end
        vectors++;
        if (snap_seq !== e.seq) begin
          miscompares++;
          $display("FAIL ack_seq: got %0d required %0d", snap_seq, e.seq);
        end
        vectors++;
        if (snap_valid !== e.valid) begin
          miscompares++;
          $display("FAIL ack_valid: got %0b required %0b", snap_valid, e.valid);
        end
        vectors++;
        if (stale !== e.stl) begin
          miscompares++;
          $display("FAIL ack_stale: got %0b required %0b", stale, e.stl);
        end
        vectors++;
        if (snap_data !== e.data) begin
          miscompares++;
          $display("FAIL ack_data: got %h required %h", snap_data, e.data);
        end
      end
    end
  end

  task automatic drain(input string tag);
    idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_ack: got %0d acks outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    vectors++;
    if ({snap_valid, snap_seq, frame_ack, frame_updated, stale} !== 12'd0 || snap_data !== '0) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b seq=%0d ack=%0b upd=%0b stale=%0b data=%h required all 0",
               tag, snap_valid, snap_seq, frame_ack, frame_updated, stale, snap_data);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check_cleared("reset_outputs");
    request();
    drain("reset_req");
  endtask

  task automatic test_publish();
    wr(5'd20, 32'h12);
    wr(5'd21, 32'h34);
    wr(5'd28, 32'hffff_ffff);
    request();
    vectors++;
    if (snap_data[31:0] !== 32'h12 || snap_data[63:32] !== 32'h34 || snap_seq !== 8'd1 || snap_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL publish_basic: got slot0=%h slot1=%h seq=%0d valid=%0b required 12 34 1 1",
               snap_data[31:0], snap_data[63:32], snap_seq, snap_valid);
    end
    drain("publish");
  endtask

  task automatic test_stale();
    wr(5'd20, 32'h55);
    for (int i = 0; i < 4; i++) request();
    vectors++;
    if (stale !== 1'b1 || snap_data[31:0] !== 32'h12) begin
      miscompares++;
      $display("FAIL stale_set: got stale=%0b slot0=%h required 1 12", stale, snap_data[31:0]);
    end
    wr(5'd28, 32'd0);
    request();
    vectors++;
    if (stale !== 1'b0 || snap_data[31:0] !== 32'h55) begin
      miscompares++;
      $display("FAIL stale_clear: got stale=%0b slot0=%h required 0 55", stale, snap_data[31:0]);
    end
    drain("stale");
  endtask

  task automatic test_same_edge_write();
    wr(5'd28, 32'd0);
    step(1'b0, 1'b1, 1'b1, 5'd22, 32'h99);
    idle(1);
    vectors++;
    if (snap_data[95:64] !== 32'h0) begin
      miscompares++;
      $display("FAIL same_edge_write_old: got slot2=%h required 0", snap_data[95:64]);
    end
    wr(5'd28, 32'd0);
    request();
    vectors++;
    if (snap_data[95:64] !== 32'h99) begin
      miscompares++;
      $display("FAIL same_edge_write_new: got slot2=%h required 99", snap_data[95:64]);
    end
    drain("same_edge_write");
  endtask

  task automatic test_same_edge_commit();
    logic [7:0] s0;
    wr(5'd28, 32'd0);
    s0 = m_seq;
    step(1'b0, 1'b1, 1'b1, 5'd28, 32'd0);
    idle(1);
    request();
    vectors++;
    if (snap_seq !== s0 + 8'd2) begin
      miscompares++;
      $display("FAIL same_edge_commit_seq: got %0d required %0d", snap_seq, s0 + 8'd2);
    end
    drain("same_edge_commit");
  endtask

  task automatic test_held_and_ignored();
    int a0;
    wr(5'd28, 32'd0);
    a0 = ack_count;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(2);
    vectors++;
    if (ack_count - a0 != 1) begin
      miscompares++;
      $display("FAIL held_req_acks: got %0d required 1", ack_count - a0);
    end
    wr(5'd0, 32'hdead_0000);
    wr(5'd19, 32'hdead_0019);
    wr(5'd29, 32'hdead_0029);
    wr(5'd28, 32'd0);
    request();
    vectors++;
    if (snap_data[31:0] !== 32'h55 || snap_data[255:96] !== '0) begin
      miscompares++;
      $display("FAIL ignored_regs: got slot0=%h upper=%h required 55 0", snap_data[31:0], snap_data[255:96]);
    end
    drain("held_ignored");
  endtask

  task automatic test_mid_reset();
    int a0;
    wr(5'd28, 32'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check_cleared("mid_reset_outputs");
    request();
    drain("mid_reset_pending");
    a0 = ack_count;
    wr(5'd28, 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(2);
    vectors++;
    if (ack_count != a0) begin
      miscompares++;
      $display("FAIL reset_kills_req: got %0d acks required 0", ack_count - a0);
    end
    drain("mid_reset_req");
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    wr(5'd24, 32'hcafe);
    wr(5'd28, 32'd0);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 1'b1, 5'd28, 32'd0);
      idle(1);
    end
    drain("wrap");
    vectors++;
    if (snap_seq !== 8'd0 || snap_valid !== 1'b1 || snap_data[159:128] !== 32'hcafe) begin
      miscompares++;
      $display("FAIL seq_wrap: got seq=%0d valid=%0b slot4=%h required 0 1 cafe",
               snap_seq, snap_valid, snap_data[159:128]);
    end
  endtask

  initial begin
    wb.ctrl_writeEnable = 1'b0;
    wb.ctrl_writeReg = '0;
    wb.data_writeReg = '0;
    model_edge(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    test_reset();
    test_publish();
    test_stale();
    test_same_edge_write();
    test_same_edge_commit();
    test_held_and_ignored();
    test_mid_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
